// File: rtl/ahfp_pkg.sv
// Shared constants and types for the ahfp single-precision add/sub datapath.
package ahfp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] INF_POS = 32'h7F800000;
  localparam logic [31:0] ZERO    = 32'h00000000;

  localparam int FLG_OVF  = 2;
  localparam int FLG_UNF  = 1;
  localparam int FLG_ZERO = 0;

  // Wide enough for in_e + 47 - 46 plus a rounding carry, and for negative underflow values.
  typedef logic signed [9:0] exp_t;

endpackage

// File: rtl/ahfp_norm_round_if.sv
// Operand/result bundle between the align-and-subtract stage and the normalise/round/pack stage.
interface ahfp_norm_round_if #(
  parameter int IN_MW = 48
);

  // start is accepted only on cycles where clk_en=1; there is no ready, every accepted
  // start yields exactly one done pulse a fixed number of enabled cycles later.
  // clk_en=0 freezes the whole pipeline including done/result/flags.
  logic             clk_en;
  logic             start;
  logic             in_s;
  logic [7:0]       in_e;
  logic [IN_MW-1:0] in_m;
  logic             done;
  logic [31:0]      result;
  logic [2:0]       flags;

  modport master (
    output clk_en, start, in_s, in_e, in_m,
    input  done, result, flags
  );

  modport slave (
    input  clk_en, start, in_s, in_e, in_m,
    output done, result, flags
  );

endinterface

// File: rtl/ahfp_lzd48.sv
// 48-bit leading-one detector: p is the index of the highest set bit, nz flags a non-zero input.
module ahfp_lzd48 (
  input  logic [47:0] a,
  output logic [5:0]  p,
  output logic        nz
);

  always_comb begin
    p = '0;
    for (int i = 0; i < 48; i++) begin
      if (a[i]) p = 6'(i);
    end
  end

  assign nz = |a;

endmodule

// File: rtl/ahfp_norm_round.sv
// Three-stage normalise/round/pack for ahfp add/sub; latency 3 enabled cycles, 1 op/cycle.
// Define AHFP_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module ahfp_norm_round
  import ahfp_pkg::*;
#(
  parameter int IN_MW      = 48,
  parameter int HIDDEN_POS = 46
) (
  input  logic              clk,
  input  logic              reset,
  ahfp_norm_round_if.slave  bus
);

  localparam int FW = 23;

  logic             v1, s1;
  logic [7:0]       e1;
  logic [IN_MW-1:0] m1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      s1 <= 1'b0;
      e1 <= '0;
      m1 <= '0;
    end else if (bus.clk_en) begin
      v1 <= bus.start;
      s1 <= bus.in_s;
      e1 <= bus.in_e;
      m1 <= bus.in_m;
    end
  end

  logic [5:0] p1;
  logic       nz1;

  ahfp_lzd48 u_lzd (
    .a  (m1),
    .p  (p1),
    .nz (nz1)
  );

  logic [5:0]    sh;
  exp_t          e_calc;
  logic [FW-1:0] frac_calc;
`ifdef AHFP_RNE_EN
  logic [IN_MW-2:0] m_n;
  logic             guard_calc, sticky_calc;
`endif

  // The leading one lands on bit IN_MW-1 and is dropped; fraction sits directly below it.
  always_comb begin
    sh     = 6'(IN_MW - 1) - p1;
    e_calc = exp_t'({2'b00, e1}) + exp_t'({4'b0000, p1}) - exp_t'(HIDDEN_POS);
`ifdef AHFP_RNE_EN
    m_n         = (IN_MW-1)'(m1 << sh);
    frac_calc   = m_n[IN_MW-2 -: FW];
    guard_calc  = m_n[IN_MW-2-FW];
    sticky_calc = |m_n[IN_MW-3-FW:0];
`else
    frac_calc   = FW'((m1 << sh) >> (IN_MW - 1 - FW));
`endif
  end

  logic          v2, s2, nz2;
  exp_t          e2;
  logic [FW-1:0] frac2;
`ifdef AHFP_RNE_EN
  logic          guard2, sticky2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      v2      <= 1'b0;
      s2      <= 1'b0;
      nz2     <= 1'b0;
      e2      <= '0;
      frac2   <= '0;
`ifdef AHFP_RNE_EN
      guard2  <= 1'b0;
      sticky2 <= 1'b0;
`endif
    end else if (bus.clk_en) begin
      v2      <= v1;
      s2      <= s1;
      nz2     <= nz1;
      e2      <= e_calc;
      frac2   <= frac_calc;
`ifdef AHFP_RNE_EN
      guard2  <= guard_calc;
      sticky2 <= sticky_calc;
`endif
    end
  end

  logic          inc;
  logic [FW:0]   sum;
  exp_t          e_r;
  logic [FW-1:0] f_r;
  logic [31:0]   res_c;
  logic [2:0]    flg_c;

  // Overflow is judged after the rounding carry so 254 can round up into infinity.
  always_comb begin
`ifdef AHFP_RNE_EN
    inc = guard2 & (sticky2 | frac2[0]);
`else
    inc = 1'b0;
`endif
    sum   = {1'b0, frac2} + {{FW{1'b0}}, inc};
    e_r   = sum[FW] ? e2 + exp_t'(1) : e2;
    f_r   = sum[FW] ? '0 : sum[FW-1:0];
    res_c = ZERO;
    flg_c = '0;
    if (!nz2) begin
      flg_c[FLG_ZERO] = 1'b1;
    end else if (e_r >= exp_t'(EXP_MAX)) begin
      res_c          = {s2, INF_POS[30:0]};
      flg_c[FLG_OVF] = 1'b1;
    end else if (e_r <= exp_t'(0)) begin
      res_c          = {s2, 31'h0};
      flg_c[FLG_UNF] = 1'b1;
    end else begin
      res_c = {s2, e_r[7:0], f_r};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.done   <= 1'b0;
      bus.result <= ZERO;
      bus.flags  <= '0;
    end else if (bus.clk_en) begin
      bus.done   <= v2;
      bus.result <= v2 ? res_c : ZERO;
      bus.flags  <= v2 ? flg_c : 3'b000;
    end
  end

endmodule
